// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer sequencing controller.
package reaction_pkg;

  localparam int unsigned MS_W             = 14;
  localparam int unsigned MAX_MS_DEF       = 9999;
  localparam int unsigned MIN_DELAY_MS_DEF = 250;
  localparam int unsigned NUM_LEDS_DEF     = 10;

  // Alternating false-start pattern; the low NUM_LEDS bits are displayed.
  localparam logic [31:0] FAULT_PATTERN = {16{2'b01}};

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_COUNTDOWN = 3'd1;
  localparam logic [2:0] ST_RAND_WAIT = 3'd2;
  localparam logic [2:0] ST_MEASURE   = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;
  localparam logic [2:0] ST_FAULT     = 3'd5;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    COUNTDOWN = ST_COUNTDOWN,
    RAND_WAIT = ST_RAND_WAIT,
    MEASURE   = ST_MEASURE,
    DONE      = ST_DONE,
    FAULT     = ST_FAULT
  } state_e;

  // Random hold-off never shorter than the configured floor.
  function automatic logic [MS_W-1:0] delay_floor(input logic [MS_W-1:0] d,
                                                  input logic [MS_W-1:0] lo);
    return (d < lo) ? lo : d;
  endfunction

endpackage

// File: rtl/reaction_timer_ctrl_if.sv
// Player-facing signal bundle of the reaction-timer controller.
interface reaction_timer_ctrl_if #(
  parameter int unsigned NUM_LEDS = reaction_pkg::NUM_LEDS_DEF
);
  import reaction_pkg::*;

  logic                start;
  logic                resp;
  logic [MS_W-1:0]     rand_delay;
  logic                lfsr_en;
  logic [NUM_LEDS-1:0] ledr;
  logic [MS_W-1:0]     result_ms;
  logic [MS_W-1:0]     best_ms;
  logic                result_valid;
  logic                false_start;
  logic                busy;

  modport master (
    output start, resp, rand_delay,
    input  lfsr_en, ledr, result_ms, best_ms, result_valid, false_start, busy
  );

  modport slave (
    input  start, resp, rand_delay,
    output lfsr_en, ledr, result_ms, best_ms, result_valid, false_start, busy
  );

endinterface

// File: rtl/rt_ms_counter.sv
// Millisecond counter shared by the hold-off countdown and the reaction measurement.
module rt_ms_counter
  import reaction_pkg::*;
#(
  parameter int unsigned MAX_MS = MAX_MS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic            clear,
  input  logic            load,
  input  logic [MS_W-1:0] load_val,
  input  logic            up,
  output logic [MS_W-1:0] count,
  output logic            sat_c
);

  localparam logic [MS_W-1:0] MAX_V = MS_W'(MAX_MS);

  // Clear beats load beats tick; both directions saturate instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick) begin
      if (up) begin
        if (count != MAX_V) count <= count + MS_W'(1);
      end else if (count != '0) begin
        count <= count - MS_W'(1);
      end
    end
  end

  assign sat_c = (count == MAX_V);

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer sequencer: LED countdown, random hold-off, response measurement.
// Define REACTION_BEST_TIME_EN to keep a best-time register; otherwise best_ms is fixed at MAX_MS.
module reaction_timer_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned NUM_LEDS     = NUM_LEDS_DEF,
  parameter int unsigned MAX_MS       = MAX_MS_DEF,
  parameter int unsigned MIN_DELAY_MS = MIN_DELAY_MS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_ms,
  input  logic                  tick_hs,
  reaction_timer_ctrl_if.slave  bus
);

  localparam int unsigned         LED_W      = $clog2(NUM_LEDS + 1);
  localparam logic [MS_W-1:0]     MAX_V      = MS_W'(MAX_MS);
  localparam logic [MS_W-1:0]     MIN_V      = MS_W'(MIN_DELAY_MS);
  localparam logic [LED_W-1:0]    LED_FULL   = LED_W'(NUM_LEDS);
  localparam logic [NUM_LEDS-1:0] FAULT_LEDS = NUM_LEDS'(FAULT_PATTERN);

  state_e              state, state_d;
  logic [LED_W-1:0]    led_cnt, led_cnt_d;
  logic                resp_q;
  logic                resp_rise_c;

  logic [MS_W-1:0]     cnt;
  logic                cnt_sat_c;
  logic                cnt_tick_c;
  logic                cnt_load_c;
  logic                cnt_clear_c;
  logic                cnt_up_c;

  logic [MS_W-1:0]     result_q, result_d;
  logic [NUM_LEDS-1:0] ledr_q, ledr_d;
  logic                lfsr_en_q, lfsr_en_d;
  logic                result_valid_q, result_valid_d;
  logic                false_start_q, false_start_d;
  logic                busy_q, busy_d;

  assign resp_rise_c = bus.resp & ~resp_q;

  rt_ms_counter #(
    .MAX_MS (MAX_MS)
  ) u_ms_counter (
    .clk      (clk),
    .rst      (rst),
    .tick     (cnt_tick_c),
    .clear    (cnt_clear_c),
    .load     (cnt_load_c),
    .load_val (delay_floor(bus.rand_delay, MIN_V)),
    .up       (cnt_up_c),
    .count    (cnt),
    .sat_c    (cnt_sat_c)
  );

  // Next state, counter control and next output values.
  always_comb begin
    state_d     = state;
    led_cnt_d   = led_cnt;
    result_d    = result_q;
    cnt_tick_c  = 1'b0;
    cnt_load_c  = 1'b0;
    cnt_clear_c = 1'b0;
    cnt_up_c    = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_d   = COUNTDOWN;
          led_cnt_d = '0;
        end
      end
      COUNTDOWN: begin
        if (resp_rise_c) begin
          state_d = FAULT;
        end else if (tick_hs) begin
          if (led_cnt == LED_FULL) begin
            state_d    = RAND_WAIT;
            cnt_load_c = 1'b1;
          end else begin
            led_cnt_d = led_cnt + LED_W'(1);
          end
        end
      end
      RAND_WAIT: begin
        // A press on the final tick is still a false start.
        if (resp_rise_c) begin
          state_d = FAULT;
        end else if (tick_ms) begin
          if (cnt <= MS_W'(1)) begin
            state_d     = MEASURE;
            cnt_clear_c = 1'b1;
          end else begin
            cnt_tick_c = 1'b1;
          end
        end
      end
      MEASURE: begin
        cnt_up_c = 1'b1;
        if (resp_rise_c) begin
          result_d = cnt;
          state_d  = DONE;
        end else if (cnt_sat_c) begin
          result_d = MAX_V;
          state_d  = DONE;
        end else begin
          cnt_tick_c = tick_ms;
        end
      end
      DONE, FAULT: begin
        // start consumes any coincident resp edge.
        if (bus.start) begin
          state_d   = COUNTDOWN;
          led_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    lfsr_en_d      = (state_d == IDLE) || (state_d == COUNTDOWN);
    busy_d         = (state_d == COUNTDOWN) || (state_d == RAND_WAIT) || (state_d == MEASURE);
    result_valid_d = (state_d == DONE);
    false_start_d  = (state_d == FAULT);

    ledr_d = '0;
    case (state_d)
      COUNTDOWN: ledr_d = NUM_LEDS'((32'd1 << led_cnt_d) - 32'd1);
      RAND_WAIT: ledr_d = '1;
      FAULT:     ledr_d = FAULT_LEDS;
      default:   ledr_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      led_cnt        <= '0;
      resp_q         <= 1'b0;
      result_q       <= '0;
      ledr_q         <= '0;
      lfsr_en_q      <= 1'b1;
      result_valid_q <= 1'b0;
      false_start_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state          <= state_d;
      led_cnt        <= led_cnt_d;
      resp_q         <= bus.resp;
      result_q       <= result_d;
      ledr_q         <= ledr_d;
      lfsr_en_q      <= lfsr_en_d;
      result_valid_q <= result_valid_d;
      false_start_q  <= false_start_d;
      busy_q         <= busy_d;
    end
  end

`ifdef REACTION_BEST_TIME_EN
  logic [MS_W-1:0] best_q;
  logic            best_upd_c;

  // Only a real response can improve the best; timeouts leave it alone.
  assign best_upd_c = (state == MEASURE) && resp_rise_c && (cnt < best_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_q <= MAX_V;
    end else if (best_upd_c) begin
      best_q <= cnt;
    end
  end

  assign bus.best_ms = best_q;
`else
  assign bus.best_ms = MAX_V;
`endif

  assign bus.lfsr_en      = lfsr_en_q;
  assign bus.ledr         = ledr_q;
  assign bus.result_ms    = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.false_start  = false_start_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Scoreboard bench for reaction_timer_ctrl: directed runs, outcomes checked by a monitor.
module tb_reaction_timer_ctrl;

`ifdef REACTION_BEST_TIME_EN
  localparam bit BEST_EN = 1'b1;
`else
  localparam bit BEST_EN = 1'b0;
`endif

  localparam logic [13:0] MAXV = 14'd9999;

  typedef struct {
    bit          is_fault;
    logic [13:0] result;
    logic [13:0] best;
  } exp_t;

  logic clk;
  logic rst;
  logic tick_ms;
  logic tick_hs;
  int unsigned cyc;

  int tests;
  int failed;

  exp_t        sb[$];
  logic [13:0] exp_result;
  logic [13:0] exp_best;
  bit          prev_rv;
  bit          prev_fs;

  reaction_timer_ctrl_if #(.NUM_LEDS(10)) bus ();

  reaction_timer_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .tick_ms (tick_ms),
    .tick_hs (tick_hs),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // tick_ms every 2 clocks, tick_hs on every 4th tick_ms.
  initial begin
    cyc     = 0;
    tick_ms = 1'b0;
    tick_hs = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      tick_ms = cyc[0];
      tick_hs = ((cyc % 8) == 1);
    end
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail_wait(input string name);
    tests++;
    failed++;
    $display("FAIL %s: wait bound expired, got no event expected one", name);
  endfunction

  function automatic logic [9:0] thermo(input int k);
    return 10'((32'd1 << k) - 32'd1);
  endfunction

  function automatic void push_done(input logic [13:0] res);
    exp_t e;
    if (BEST_EN && res < exp_best) exp_best = res;
    exp_result = res;
    e.is_fault = 1'b0;
    e.result   = res;
    e.best     = exp_best;
    sb.push_back(e);
  endfunction

  function automatic void push_timeout();
    exp_t e;
    exp_result = MAXV;
    e.is_fault = 1'b0;
    e.result   = MAXV;
    e.best     = exp_best;
    sb.push_back(e);
  endfunction

  function automatic void push_fault();
    exp_t e;
    e.is_fault = 1'b1;
    e.result   = exp_result;
    e.best     = exp_best;
    sb.push_back(e);
  endfunction

  // Monitor: every new DONE/FAULT outcome pops one expectation.
  initial begin
    exp_t e;
    prev_rv = 1'b0;
    prev_fs = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if ((bus.result_valid && !prev_rv) || (bus.false_start && !prev_fs)) begin
        if (sb.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL sb_unexpected: got rv=%0b fs=%0b expected no outcome",
                   bus.result_valid, bus.false_start);
        end else begin
          e = sb.pop_front();
          check("sb_kind", 32'({bus.result_valid, bus.false_start}),
                e.is_fault ? 32'd1 : 32'd2);
          check("sb_result", 32'(bus.result_ms), 32'(e.result));
          check("sb_best", 32'(bus.best_ms), 32'(e.best));
          check("sb_ledr", 32'(bus.ledr), e.is_fault ? 32'h155 : 32'h0);
          check("sb_busy", 32'(bus.busy), 32'd0);
        end
      end
      prev_rv = bus.result_valid;
      prev_fs = bus.false_start;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_outcome();
    for (int s = 0; s < 25000; s++) begin
      if (bus.result_valid || bus.false_start) return;
      step();
    end
    fail_wait("outcome_wait");
  endtask

  // Follows the LED fill until RAND_WAIT is entered.
  task automatic run_countdown(input bit chk);
    int k;
    bit hs;
    k = 0;
    if (chk) begin
      check("cd_entry_ledr", 32'(bus.ledr), 32'h0);
      check("cd_entry_busy", 32'(bus.busy), 32'd1);
    end
    for (int s = 0; s < 400; s++) begin
      hs = tick_hs;
      step();
      if (hs) begin
        if (k == 10) begin
          if (chk) begin
            check("rw_lfsr_en", 32'(bus.lfsr_en), 32'd0);
            check("rw_ledr", 32'(bus.ledr), 32'h3FF);
          end
          return;
        end
        k++;
        if (chk) begin
          check("led_fill", 32'(bus.ledr), 32'(thermo(k)));
          check("cd_lfsr_en", 32'(bus.lfsr_en), 32'd1);
        end
      end
    end
    fail_wait("countdown_wait");
  endtask

  // Counts hold-off ticks until MEASURE; optionally presses on the final tick.
  task automatic run_rand_wait(input int exp_ms, input bit fault_final);
    int n;
    n = 0;
    for (int s = 0; s < 4 * exp_ms + 40; s++) begin
      if (bus.busy && bus.ledr == '0) begin
        check("rw_length", 32'(n), 32'(exp_ms));
        return;
      end
      if (fault_final && tick_ms && n == exp_ms - 1) begin
        push_fault();
        bus.resp = 1'b1;
        step();
        bus.resp = 1'b0;
        wait_outcome();
        return;
      end
      if (tick_ms) n++;
      step();
    end
    fail_wait("rand_wait_wait");
  endtask

  // Presses after n_ms measured ticks, optionally on a tick_ms clock.
  task automatic respond_after(input int n_ms, input bit on_tick);
    int n;
    n = 0;
    for (int s = 0; s < 4 * n_ms + 40; s++) begin
      if (n == n_ms && (!on_tick || tick_ms)) begin
        push_done(14'(n_ms));
        bus.resp = 1'b1;
        step();
        bus.resp = 1'b0;
        wait_outcome();
        return;
      end
      if (tick_ms) n++;
      step();
    end
    fail_wait("respond_wait");
  endtask

  task automatic best_run(input int ms);
    do_start();
    run_countdown(1'b0);
    run_rand_wait(250, 1'b0);
    respond_after(ms, 1'b0);
  endtask

  initial begin
    tests          = 0;
    failed         = 0;
    exp_result     = 14'd0;
    exp_best       = MAXV;
    bus.start      = 1'b0;
    bus.resp       = 1'b0;
    bus.rand_delay = 14'd0;
    rst            = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    check("rst_ledr", 32'(bus.ledr), 32'h0);
    check("rst_lfsr_en", 32'(bus.lfsr_en), 32'd1);
    check("rst_result", 32'(bus.result_ms), 32'd0);
    check("rst_best", 32'(bus.best_ms), 32'(MAXV));
    check("rst_flags", 32'({bus.result_valid, bus.false_start, bus.busy}), 32'd0);

    // Normal run: 1000 ms hold-off, 180 ms reaction.
    bus.rand_delay = 14'd1000;
    do_start();
    run_countdown(1'b1);
    run_rand_wait(1000, 1'b0);
    respond_after(180, 1'b0);

    // False start on the final hold-off tick, then restart.
    bus.rand_delay = 14'd300;
    do_start();
    run_countdown(1'b0);
    run_rand_wait(300, 1'b1);
    bus.rand_delay = 14'd10;
    do_start();
    check("fault_restart_busy", 32'(bus.busy), 32'd1);
    check("fault_restart_fs", 32'(bus.false_start), 32'd0);

    // Delay floor and timeout.
    run_countdown(1'b0);
    run_rand_wait(250, 1'b0);
    push_timeout();
    wait_outcome();

    // start and resp rising together in DONE.
    bus.rand_delay = 14'd0;
    bus.start = 1'b1;
    bus.resp  = 1'b1;
    step();
    bus.start = 1'b0;
    check("start_wins_busy", 32'(bus.busy), 32'd1);
    check("start_wins_fs", 32'(bus.false_start), 32'd0);
    check("start_wins_rv", 32'(bus.result_valid), 32'd0);
    step();
    bus.resp = 1'b0;
    run_countdown(1'b0);
    run_rand_wait(250, 1'b0);
    respond_after(42, 1'b1);

    // Reset in the middle of MEASURE.
    do_start();
    run_countdown(1'b0);
    run_rand_wait(250, 1'b0);
    repeat (20) step();
    rst = 1'b1;
    #1;
    check("mid_rst_ledr", 32'(bus.ledr), 32'h0);
    check("mid_rst_lfsr_en", 32'(bus.lfsr_en), 32'd1);
    check("mid_rst_best", 32'(bus.best_ms), 32'(MAXV));
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_result", 32'(bus.result_ms), 32'd0);
    step();
    rst = 1'b0;
    exp_result = 14'd0;
    exp_best   = MAXV;
    step();

    // Best-time tracking.
    best_run(300);
    best_run(200);
    best_run(250);

    repeat (4) step();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/reaction_timer_ctrl.md
# reaction_timer_ctrl

Sequencing controller for the reaction-timer game. Drives the starting-line LED countdown, freezes the LFSR to capture a random hold-off, waits that many milliseconds, then measures the player's response in milliseconds and latches the result for the BCD/7-segment display path. Also detects false starts and, optionally, tracks the best time. It replaces the separate starting-line FSM plus delay counter pairing at the top level.

## Interface
- `NUM_LEDS`, 10: starting-line LEDs lit one per `tick_hs`.
- `MAX_MS`, 9999: reaction-count ceiling; also the timeout value.
- `MIN_DELAY_MS`, 250: floor applied to the captured random delay.

- `clk`  in  1  system clock (CLOCK_50 domain).
- `rst`  in  1  reset, asynchronous, active-high.
- `tick_ms`  in  1  one-`clk` pulse every 1 ms.
- `tick_hs`  in  1  one-`clk` pulse every 0.5 s, coincident with a `tick_ms`.
- `start`  in  1  active-high, one-`clk` pulse (debounced KEY[3], inverted upstream).
- `resp`  in  1  response button level, active-high, already synchronised.
- `rand_delay`  in  14  LFSR output.
- `lfsr_en`  out  1  LFSR advance enable.
- `ledr`  out  `NUM_LEDS`  starting-line LEDs.
- `result_ms`  out  14  last reaction time, binary.
- `best_ms`  out  14  best reaction time, binary.
- `result_valid`  out  1  high while a valid result is displayed.
- `false_start`  out  1  high while in FAULT.
- `busy`  out  1  high in COUNTDOWN, RAND_WAIT, and MEASURE.

## Operation
- States are IDLE, COUNTDOWN, RAND_WAIT, MEASURE, DONE, and FAULT.
- `resp_rise = resp & ~resp_q`, where `resp_q` is registered every `clk`. Only rising edges count.
- **IDLE.** `ledr` is 0 and `lfsr_en` is 1. On `start`: go to COUNTDOWN and set the LED count to 0.
- **COUNTDOWN.** `ledr` is a thermometer of the LED count, and `lfsr_en` is 1.
  - Each `tick_hs` increments the count.
  - On the `tick_hs` that occurs when the count equals `NUM_LEDS`, go to RAND_WAIT. On that edge, load the delay counter with `max(rand_delay, MIN_DELAY_MS)`.
- **RAND_WAIT.** `ledr` is all ones and `lfsr_en` is 0.
  - Each `tick_ms` decrements the counter.
  - When `tick_ms` arrives with the counter at 1, go to MEASURE, clear the counter, and set `ledr` to 0.
- **MEASURE.** Each `tick_ms` increments the counter.
  - On `resp_rise`: `result_ms` takes the current count and the state goes to DONE.
  - If the count reaches `MAX_MS` first: `result_ms` is set to `MAX_MS` and the state goes to DONE (timeout).
- **FAULT trigger.** A `resp_rise` in COUNTDOWN or RAND_WAIT goes to FAULT. `result_ms` is left unchanged.
- **DONE.** `result_valid` is 1 and `ledr` is 0. `start` goes to COUNTDOWN.
- **FAULT.** `false_start` is 1 and `ledr` is the alternating pattern `10'b0101010101`. `start` goes to COUNTDOWN.
- **Ignored `start`.** `start` has no effect in COUNTDOWN, RAND_WAIT, and MEASURE.
- **Arithmetic.** All counts are 14-bit unsigned. The measure count saturates at `MAX_MS` and never wraps.

## Timing
- **Reset values.** State is IDLE and all outputs are 0, except:
  - `lfsr_en` is 1;
  - `best_ms` is `MAX_MS`.
- **Reset mid-run.** Asynchronous; returns to IDLE immediately from any state.
- **Output latency.** Outputs are registered. State changes are visible one `clk` after the triggering edge. `result_ms` and `result_valid` appear 1 `clk` after the `clk` on which `resp_rise` is seen.
- **`resp_rise` and `tick_ms` on the same `clk` in MEASURE.** `resp` wins; the result is the pre-increment count.
- **`resp_rise` and the final `tick_ms` on the same `clk` in RAND_WAIT.** FAULT wins.
- **`start` and `resp_rise` on the same `clk` in DONE/FAULT.** `start` wins. The edge is consumed and does not cause a false start.
- **Reaction resolution.** The result is quantised to whole ms and reads 0 when `resp` arrives before the first `tick_ms` in MEASURE.

## Configuration
- `REACTION_BEST_TIME_EN` defined:
  - On entry to DONE via `resp_rise` with `result_ms < best_ms`, `best_ms` is updated on the same edge as `result_ms`.
  - Timeouts never update `best_ms`.
- Undefined: the register is removed and `best_ms` is tied to `MAX_MS`.

## Structure
- Shared package `reaction_pkg` holds:
  - the state encoding (3-bit localparams);
  - `MS_W = 14`;
  - the default `MAX_MS` and `MIN_DELAY_MS`;
  - `FAULT_PATTERN`.
- Sub-module `rt_ms_counter`: a 14-bit counter with load, clear, and up/down selection, enabled by `tick_ms`, with a saturation flag at `MAX_MS`. It is shared by RAND_WAIT and MEASURE.
- The controller is a single FSM plus the `resp` edge detector and the result/best registers.

## Test plan
- **Normal run.** Reset, `start`, `rand_delay=1000`, `resp` rising 180 ms after MEASURE entry:
  - LEDs fill 1 through 10 on successive `tick_hs`, and `lfsr_en` drops when RAND_WAIT is entered.
  - MEASURE is entered after 1000 `tick_ms`.
  - Expect `result_ms=180`, `result_valid=1`, `best_ms=180` (with `_EN`).
- **False start.** `resp` rises in RAND_WAIT → FAULT, `false_start=1`, `ledr=0101010101`, `result_ms` unchanged. A following `start` re-enters COUNTDOWN.
- **Delay floor and timeout.** `rand_delay=10` → RAND_WAIT lasts exactly 250 `tick_ms`. With no `resp`, `result_ms=9999` after 9999 ms and `best_ms` is unchanged.
- **Simultaneous events.** `resp_rise` on the same `clk` as `tick_ms` with the count at 42 → `result_ms=42`. `start` and `resp_rise` together in DONE → COUNTDOWN, no FAULT.
- **Best tracking.** Runs of 300, 200, then 250 ms → `best_ms` reads 300, then 200, then stays 200. Without the macro, `best_ms` stays 9999.
- **Reset mid-run.** Assert `rst` in MEASURE → immediate IDLE, `ledr=0`, `best_ms=9999`, `lfsr_en=1`.
